// File: rtl/divu_if.sv
// Start/busy handshake and operand/result bus between the pipeline and the DIVU unit.
// The pipeline side uses the master modport and the divider uses the slave modport.
interface divu_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] q;
   logic [31:0] r;
   logic        busy;

   modport master (
      output start,
      output a,
      output b,
      input  q,
      input  r,
      input  busy
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output q,
      output r,
      output busy
   );
endinterface

// File: rtl/divu.sv
// Multicycle unsigned 32-bit restoring divider: one quotient bit per falling clock edge.
// The quotient is driven to LO (q) and the remainder to HI (r).
module divu (
   input  logic  clk,
   input  logic  resetn,
   divu_if.slave bus
);

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] q_q, q_d;
   logic [31:0] r_q, r_d;
   logic        busy_q, busy_d;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic [31:0] remNext;
   logic [31:0] quoNext;

   // The partial remainder is always below the divisor, so its 33rd bit is never set and is not stored.
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, dvs_q};

   always_ff @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         count_q <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         count_q <= count_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      count_d = count_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      remNext = shifted[31:0];
      quoNext = {quo_q[30:0], 1'b0};

      if (!diff[32]) begin
         remNext = diff[31:0];
         quoNext = {quo_q[30:0], 1'b1};
      end

      // A start always wins, abandoning any divide in flight.
      if (bus.start) begin
         if (bus.b != 32'd0) begin
            rem_d   = '0;
            quo_d   = bus.a;
            dvs_d   = bus.b;
            count_d = '0;
            busy_d  = 1'b1;
            state_d = CALC;
         end else begin
            q_d     = 32'hFFFF_FFFF;
            r_d     = bus.a;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end else if (state_q == CALC) begin
         rem_d   = remNext;
         quo_d   = quoNext;
         count_d = count_q + 5'd1;
         if (count_q == 5'd31) begin
            q_d     = quoNext;
            r_d     = remNext;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end
   end

   assign bus.q    = q_q;
   assign bus.r    = r_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_divu.sv
// Randomized self-checking bench for divu against a plain-arithmetic quotient/remainder model.
module tb_divu;

   logic clk;
   logic resetn;
   int   nVectors;
   int   nMiscompares;
   logic [31:0] expQ;
   logic [31:0] expR;

   divu_if bus ();

   divu dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] refQ(input logic [31:0] av, input logic [31:0] bv);
      return (bv == 32'd0) ? 32'hFFFF_FFFF : av / bv;
   endfunction

   function automatic logic [31:0] refR(input logic [31:0] av, input logic [31:0] bv);
      return (bv == 32'd0) ? av : av % bv;
   endfunction

   // Launch one divide, release start after E0, and count posedges with busy high while q/r must hold.
   task automatic runDiv(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] holdQ, input logic [31:0] holdR,
                         output int busyLen, output bit holdOk);
      @(posedge clk);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(negedge clk);
      @(posedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      busyLen   = 0;
      holdOk    = 1'b1;
      while (bus.busy === 1'b1 && busyLen < 64) begin
         if (bus.q !== holdQ || bus.r !== holdR) holdOk = 1'b0;
         busyLen++;
         @(posedge clk);
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      resetn    = 1'b0;
      repeat (3) @(posedge clk);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      expQ = '0;
      expR = '0;
      nVectors++;
      if (bus.q !== 32'd0 || bus.r !== 32'd0 || bus.busy !== 1'b0) begin
         $display("[TB] FAIL reset: q=%h r=%h busy=%b, required q=0 r=0 busy=0", bus.q, bus.r, bus.busy);
         nMiscompares++;
      end
   endtask

   task automatic test_basic;
      int len;
      bit holdOk;
      runDiv(32'd100, 32'd7, expQ, expR, len, holdOk);
      nVectors++;
      if (len != 32) begin
         $display("[TB] FAIL basic_busy_len: got %0d, required 32", len);
         nMiscompares++;
      end
      nVectors++;
      if (!holdOk) begin
         $display("[TB] FAIL basic_hold: q/r changed while busy, required %h/%h", expQ, expR);
         nMiscompares++;
      end
      expQ = 32'd14;
      expR = 32'd2;
      nVectors++;
      if (bus.q !== expQ || bus.r !== expR) begin
         $display("[TB] FAIL basic_result: q=%0d r=%0d, required q=%0d r=%0d", bus.q, bus.r, expQ, expR);
         nMiscompares++;
      end
   endtask

   task automatic test_boundary;
      logic [31:0] av [3];
      logic [31:0] bv [3];
      logic [31:0] wq [3];
      logic [31:0] wr [3];
      int len;
      bit holdOk;
      av = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
      bv = '{32'd1,         32'hFFFF_FFFF, 32'd9};
      wq = '{32'hFFFF_FFFF, 32'd1,         32'd0};
      wr = '{32'd0,         32'd0,         32'd5};
      for (int i = 0; i < 3; i++) begin
         runDiv(av[i], bv[i], expQ, expR, len, holdOk);
         expQ = wq[i];
         expR = wr[i];
         nVectors++;
         if (bus.q !== expQ || bus.r !== expR || len != 32 || !holdOk) begin
            $display("[TB] FAIL boundary_%0d: q=%h r=%h len=%0d hold=%b, required q=%h r=%h len=32 hold=1",
                     i, bus.q, bus.r, len, holdOk, expQ, expR);
            nMiscompares++;
         end
      end
   endtask

   task automatic test_div_zero;
      int len;
      bit holdOk;
      bit busySeen;
      runDiv(32'd1234, 32'd0, expQ, expR, len, holdOk);
      expQ = 32'hFFFF_FFFF;
      expR = 32'd1234;
      nVectors++;
      if (bus.q !== expQ || bus.r !== expR) begin
         $display("[TB] FAIL divzero_result: q=%h r=%0d, required q=%h r=%0d", bus.q, bus.r, expQ, expR);
         nMiscompares++;
      end
      busySeen = (len != 0);
      repeat (5) begin
         @(posedge clk);
         if (bus.busy !== 1'b0) busySeen = 1'b1;
      end
      nVectors++;
      if (busySeen) begin
         $display("[TB] FAIL divzero_busy: busy asserted (len=%0d), required never", len);
         nMiscompares++;
      end
   endtask

   task automatic test_restart;
      int len;
      bit ok;
      bit holdOk;
      ok = 1'b1;
      @(posedge clk);
      bus.start = 1'b1;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      @(negedge clk);
      @(posedge clk);
      bus.start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         @(posedge clk);
         if (bus.busy !== 1'b1 || bus.q !== expQ || bus.r !== expR) ok = 1'b0;
      end
      runDiv(32'd1000, 32'd3, expQ, expR, len, holdOk);
      nVectors++;
      if (!ok || !holdOk || len != 32) begin
         $display("[TB] FAIL restart_busy: continuous=%b hold=%b len=%0d, required 1/1/32", ok, holdOk, len);
         nMiscompares++;
      end
      expQ = 32'd333;
      expR = 32'd1;
      nVectors++;
      if (bus.q !== expQ || bus.r !== expR) begin
         $display("[TB] FAIL restart_result: q=%0d r=%0d, required q=%0d r=%0d", bus.q, bus.r, expQ, expR);
         nMiscompares++;
      end
   endtask

   task automatic test_back_to_back;
      int len;
      bit ok;
      bit holdOk;
      logic [31:0] av [3];
      logic [31:0] bv [3];
      ok = 1'b1;
      av = '{32'd77, 32'd5000, 32'hDEAD_BEEF};
      bv = '{32'd3,  32'd11,   32'd12345};
      @(posedge clk);
      bus.start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.a = av[i];
         bus.b = bv[i];
         @(negedge clk);
         @(posedge clk);
         if (bus.busy !== 1'b1 || bus.q !== expQ || bus.r !== expR) ok = 1'b0;
      end
      bus.start = 1'b0;
      runDiv(av[2], bv[2], expQ, expR, len, holdOk);
      nVectors++;
      if (!ok || !holdOk || len != 32) begin
         $display("[TB] FAIL b2b_busy: continuous=%b hold=%b len=%0d, required 1/1/32", ok, holdOk, len);
         nMiscompares++;
      end
      expQ = refQ(av[2], bv[2]);
      expR = refR(av[2], bv[2]);
      nVectors++;
      if (bus.q !== expQ || bus.r !== expR) begin
         $display("[TB] FAIL b2b_result: q=%h r=%h, required q=%h r=%h", bus.q, bus.r, expQ, expR);
         nMiscompares++;
      end
   endtask

   task automatic test_mid_reset;
      bit ok;
      @(posedge clk);
      bus.start = 1'b1;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      @(negedge clk);
      @(posedge clk);
      bus.start = 1'b0;
      repeat (15) @(negedge clk);
      @(posedge clk);
      resetn = 1'b0;
      #1;
      expQ = '0;
      expR = '0;
      nVectors++;
      if (bus.busy !== 1'b0 || bus.q !== expQ || bus.r !== expR) begin
         $display("[TB] FAIL midreset_now: busy=%b q=%h r=%h, required 0/0/0", bus.busy, bus.q, bus.r);
         nMiscompares++;
      end
      @(posedge clk);
      resetn = 1'b1;
      ok = 1'b1;
      repeat (40) begin
         @(posedge clk);
         if (bus.busy !== 1'b0 || bus.q !== expQ || bus.r !== expR) ok = 1'b0;
      end
      nVectors++;
      if (!ok) begin
         $display("[TB] FAIL midreset_after: busy=%b q=%h r=%h, required all 0 held", bus.busy, bus.q, bus.r);
         nMiscompares++;
      end
   endtask

   task automatic test_random;
      logic [31:0] av;
      logic [31:0] bv;
      logic [63:0] recon;
      int len;
      int wantLen;
      bit holdOk;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0: begin bv = 32'd0;                     av = $urandom; end
            1: begin bv = $urandom | 32'd1;          av = $urandom % bv; end
            2: begin bv = $urandom_range(1, 15);     av = $urandom; end
            default: begin bv = $urandom >> $urandom_range(0, 31); av = $urandom; end
         endcase
         runDiv(av, bv, expQ, expR, len, holdOk);
         wantLen = (bv == 32'd0) ? 0 : 32;
         expQ = refQ(av, bv);
         expR = refR(av, bv);
         nVectors++;
         if (len != wantLen || !holdOk) begin
            $display("[TB] FAIL rand_busy a=%h b=%h: len=%0d hold=%b, required len=%0d hold=1", av, bv, len, holdOk, wantLen);
            nMiscompares++;
         end
         nVectors++;
         if (bus.q !== expQ || bus.r !== expR) begin
            $display("[TB] FAIL rand_result a=%h b=%h: q=%h r=%h, required q=%h r=%h", av, bv, bus.q, bus.r, expQ, expR);
            nMiscompares++;
         end
         if (bv != 32'd0) begin
            recon = 64'(bus.q) * 64'(bv) + 64'(bus.r);
            nVectors++;
            if (recon !== 64'(av) || bus.r >= bv) begin
               $display("[TB] FAIL rand_identity a=%h b=%h: q*b+r=%h r=%h, required q*b+r=%h r<b", av, bv, recon, bus.r, av);
               nMiscompares++;
            end
         end
      end
   endtask

   initial begin
      nVectors     = 0;
      nMiscompares = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_div_zero();
      test_restart();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
